// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Each accepted operation takes IDLE -> EXEC -> RESP and returns its result/flags to the owner.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [3:0]       req0_op,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req0_ci,
    input  logic             req1_ci,
    input  logic             req0_s,
    input  logic             req1_s,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_ci,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_n,
    input  logic             alu_z,
    input  logic             alu_v,
    input  logic             alu_co,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp_y,
    output logic [3:0]       rsp_nzvc,
    output logic [3:0]       flags,
    output logic             busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0] state_reg;
    logic [1:0] state_next;
    logic       last_grant_reg;
    logic       s_reg;
    logic       id_reg;
    logic       grant;
    logic       handshake;

    // On a tie the requester that did not win last time gets the slot.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_reg;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign handshake  = (state_reg == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = handshake && !grant;
    assign req1_ready = handshake && grant;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (handshake) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            s_reg          <= 1'b0;
            id_reg         <= 1'b0;
            alu_op         <= '0;
            alu_a          <= '0;
            alu_b          <= '0;
            alu_ci         <= 1'b0;
            rsp_y          <= '0;
            rsp_nzvc       <= '0;
            flags          <= '0;
        end else begin
            state_reg <= state_next;
            if (handshake) begin
                last_grant_reg <= grant;
                id_reg         <= grant;
                s_reg          <= grant ? req1_s  : req0_s;
                alu_op         <= grant ? req1_op : req0_op;
                alu_a          <= grant ? req1_a  : req0_a;
                alu_b          <= grant ? req1_b  : req0_b;
                alu_ci         <= grant ? req1_ci : req0_ci;
            end
            // The ALU has had the whole EXEC cycle to settle on the latched operands.
            if (state_reg == EXEC) begin
                rsp_y    <= alu_y;
                rsp_nzvc <= {alu_n, alu_z, alu_v, alu_co};
                if (s_reg) begin
                    flags <= {alu_n, alu_z, alu_v, alu_co};
                end
            end
        end
    end

    assign rsp0_valid = (state_reg == RESP) && !id_reg;
    assign rsp1_valid = (state_reg == RESP) && id_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU on the alu_* bus.
// Directed transactions push expected responses; a negedge monitor pops and compares them.
module tb_alu_arbiter;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [3:0]       req0_op = '0, req1_op = '0;
    logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic             req0_ci = 1'b0, req1_ci = 1'b0, req0_s = 1'b0, req1_s = 1'b0;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_a, alu_b, alu_y;
    logic             alu_ci, alu_n, alu_z, alu_v, alu_co;
    logic             rsp0_valid, rsp1_valid;
    logic [WIDTH-1:0] rsp_y;
    logic [3:0]       rsp_nzvc, flags;
    logic             busy;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int          id;
        logic [31:0] y;
        logic [3:0]  nzvc;
        logic [3:0]  flags;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_op(req0_op), .req1_op(req1_op),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_ci(req0_ci), .req1_ci(req1_ci), .req0_s(req0_s), .req1_s(req1_s),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_ci(alu_ci),
        .alu_y(alu_y), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .alu_co(alu_co),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp_y(rsp_y), .rsp_nzvc(rsp_nzvc), .flags(flags), .busy(busy)
    );

    // External ALU: 4 = add with carry, 2 = subtract, 0 = and (C passes ci), else xor.
    always_comb begin
        logic [32:0] sum;
        sum    = '0;
        alu_y  = '0;
        alu_co = 1'b0;
        alu_v  = 1'b0;
        case (alu_op)
            4'd4: begin
                sum    = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_ci};
                alu_y  = sum[31:0];
                alu_co = sum[32];
                alu_v  = (alu_a[31] == alu_b[31]) && (alu_y[31] != alu_a[31]);
            end
            4'd2: begin
                sum    = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
                alu_y  = sum[31:0];
                alu_co = sum[32];
                alu_v  = (alu_a[31] != alu_b[31]) && (alu_y[31] != alu_a[31]);
            end
            4'd0: begin
                alu_y  = alu_a & alu_b;
                alu_co = alu_ci;
            end
            default: alu_y = alu_a ^ alu_b;
        endcase
        alu_n = alu_y[31];
        alu_z = (alu_y == '0);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every response pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && (rsp0_valid || rsp1_valid)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_both", {63'd0, rsp0_valid & rsp1_valid}, 64'd0);
                chk("rsp_id", {63'd0, rsp1_valid}, e.id[0] ? 64'd1 : 64'd0);
                chk("rsp_y", {32'd0, rsp_y}, {32'd0, e.y});
                chk("rsp_nzvc", {60'd0, rsp_nzvc}, {60'd0, e.nzvc});
                chk("flags", {60'd0, flags}, {60'd0, e.flags});
                $display("rsp%0d y=%h nzvc=%b flags=%b", rsp1_valid, rsp_y, rsp_nzvc, flags);
            end
        end
    end

    task automatic set_req(input int id, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic ci, input logic s);
        if (id == 0) begin
            req0_op = op; req0_a = a; req0_b = b; req0_ci = ci; req0_s = s; req0_valid = 1'b1;
        end else begin
            req1_op = op; req1_a = a; req1_b = b; req1_ci = ci; req1_s = s; req1_valid = 1'b1;
        end
    endtask

    task automatic expect_rsp(input int id, input logic [31:0] y, input logic [3:0] nzvc,
                              input logic [3:0] fl);
        exp_t e;
        e.id = id; e.y = y; e.nzvc = nzvc; e.flags = fl;
        exp_q.push_back(e);
    endtask

    function automatic logic rdy_of(input int id);
        return (id == 0) ? req0_ready : req1_ready;
    endfunction

    function automatic logic rsp_of(input int id);
        return (id == 0) ? rsp0_valid : rsp1_valid;
    endfunction

    // Single-requester transaction with latency and pass-through checks.
    task automatic txn(input int id, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic ci, input logic s,
                       input logic [31:0] ey, input logic [3:0] enzvc, input logic [3:0] efl);
        int   n;
        logic rdy;
        expect_rsp(id, ey, enzvc, efl);
        set_req(id, op, a, b, ci, s);
        n = 0;
        do begin
            @(negedge clk);
            rdy = rdy_of(id);
            n++;
        end while (!rdy && n < 10);
        chk("ready", {63'd0, rdy}, 64'd1);
        chk("other_ready", {63'd0, rdy_of(1 - id)}, 64'd0);
        @(posedge clk); #1;
        if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        @(negedge clk);
        chk("busy_exec", {63'd0, busy}, 64'd1);
        chk("alu_op", {60'd0, alu_op}, {60'd0, op});
        chk("alu_a", {32'd0, alu_a}, {32'd0, a});
        chk("alu_b", {32'd0, alu_b}, {32'd0, b});
        chk("alu_ci", {63'd0, alu_ci}, {63'd0, ci});
        chk("rsp_early", {63'd0, rsp_of(id)}, 64'd0);
        @(negedge clk);
        chk("rsp_latency", {63'd0, rsp_of(id)}, 64'd1);
        chk("rsp_other", {63'd0, rsp_of(1 - id)}, 64'd0);
        @(negedge clk);
        chk("rsp_single", {63'd0, rsp_of(id)}, 64'd0);
        chk("busy_idle", {63'd0, busy}, 64'd0);
        $display("txn req%0d op=%0d a=%h b=%h ci=%0d s=%0d", id, op, a, b, ci, s);
        @(posedge clk); #1;
    endtask

    task automatic wait_done();
        repeat (3) @(negedge clk);
        chk("idle_after", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_rsp", {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
        chk("rst_flags", {60'd0, flags}, 64'd0);
        chk("rst_rsp_y", {32'd0, rsp_y}, 64'd0);
        chk("rst_rsp_nzvc", {60'd0, rsp_nzvc}, 64'd0);
        chk("rst_alu", {27'd0, alu_ci, alu_op, alu_a}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        txn(0, 4'd4, 32'd10, 32'd15, 1'b0, 1'b1, 32'd25, 4'b0000, 4'b0000);
        txn(1, 4'd4, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, 32'h8000_0000, 4'b1010, 4'b1010);
        txn(0, 4'd2, 32'd5, 32'd5, 1'b0, 1'b0, 32'd0, 4'b0101, 4'b1010);
        txn(1, 4'd0, 32'hF0F0_F0F0, 32'h0FF0_FF00, 1'b1, 1'b1, 32'h00F0_F000, 4'b0001, 4'b0001);
        txn(0, 4'd4, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b1, 32'd0, 4'b0101, 4'b0101);

        // Both requesters valid continuously from reset release: strict alternation.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            expect_rsp(0, 32'd3, 4'b0000, 4'b0000);
            expect_rsp(1, 32'd300, 4'b0000, 4'b0000);
        end
        set_req(0, 4'd4, 32'd1, 32'd2, 1'b0, 1'b0);
        set_req(1, 4'd4, 32'd100, 32'd200, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("rr_ready0", {63'd0, req0_ready}, ((k % 3 == 0) && ((k / 3) % 2 == 0)) ? 64'd1 : 64'd0);
            chk("rr_ready1", {63'd0, req1_ready}, ((k % 3 == 0) && ((k / 3) % 2 == 1)) ? 64'd1 : 64'd0);
            chk("rr_busy", {63'd0, busy}, (k % 3 != 0) ? 64'd1 : 64'd0);
            @(posedge clk); #1;
            if (k == 9) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end
        wait_done();

        // Reset during EXEC aborts the operation and restores req0 tie priority.
        txn(1, 4'd4, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, 32'h8000_0000, 4'b1010, 4'b1010);
        set_req(0, 4'd4, 32'd3, 32'd4, 1'b0, 1'b1);
        @(negedge clk);
        chk("abort_ready0", {63'd0, req0_ready}, 64'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("abort_busy", {63'd0, busy}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_async_busy", {63'd0, busy}, 64'd0);
        chk("abort_alu", {27'd0, alu_ci, alu_op, alu_a}, 64'd0);
        chk("abort_alu_b", {32'd0, alu_b}, 64'd0);
        chk("abort_flags", {60'd0, flags}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        expect_rsp(0, 32'd2, 4'b0000, 4'b0000);
        set_req(0, 4'd4, 32'd1, 32'd1, 1'b0, 1'b0);
        set_req(1, 4'd4, 32'd50, 32'd50, 1'b0, 1'b0);
        @(negedge clk);
        chk("abort_no_rsp", {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
        chk("tie_after_rst_r0", {63'd0, req0_ready}, 64'd1);
        chk("tie_after_rst_r1", {63'd0, req1_ready}, 64'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_done();

        // req1 raised and withdrawn while req0 executes: no effect on arbitration.
        expect_rsp(0, 32'd7, 4'b0000, 4'b0000);
        set_req(0, 4'd4, 32'd3, 32'd4, 1'b0, 1'b0);
        @(negedge clk);
        chk("wd_ready0", {63'd0, req0_ready}, 64'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        set_req(1, 4'd2, 32'd9, 32'd1, 1'b0, 1'b1);
        @(negedge clk);
        chk("wd_ready1_exec", {63'd0, req1_ready}, 64'd0);
        req1_valid = 1'b0;
        wait_done();
        expect_rsp(1, 32'd16, 4'b0000, 4'b0000);
        set_req(0, 4'd4, 32'd2, 32'd2, 1'b0, 1'b0);
        set_req(1, 4'd4, 32'd8, 32'd8, 1'b0, 1'b0);
        @(negedge clk);
        chk("wd_tie_r1", {63'd0, req1_ready}, 64'd1);
        chk("wd_tie_r0", {63'd0, req0_ready}, 64'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_done();
        txn(1, 4'd2, 32'd10, 32'd3, 1'b0, 1'b1, 32'd7, 4'b0001, 4'b0001);

        repeat (2) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand/result width.
REQ-002 The module SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 The module SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The module SHALL have ports req0_valid / req1_valid  input  1  requester i has an operation pending.
REQ-005 The module SHALL have ports req0_ready / req1_ready  output  1  request accepted this cycle.
REQ-006 The module SHALL have ports req0_op / req1_op  input  4  ALU opcode.
REQ-007 The module SHALL have ports req0_a, req0_b, req1_a, req1_b  input  WIDTH  operands.
REQ-008 The module SHALL have ports req0_ci / req1_ci  input  1  carry-in.
REQ-009 The module SHALL have ports req0_s / req1_s  input  1  update flag register.
REQ-010 The module SHALL have ports alu_op  output  4; alu_a, alu_b  output  WIDTH; alu_ci  output  1: registered drive to the shared combinational ALU.
REQ-011 The module SHALL have ports alu_y  input  WIDTH; alu_n, alu_z, alu_v, alu_co  input  1: ALU result and flags.
REQ-012 The module SHALL have ports rsp0_valid / rsp1_valid  output  1  one-cycle result pulse to requester i.
REQ-013 The module SHALL have ports rsp_y  output  WIDTH; rsp_nzvc  output  4  {N,Z,V,C} of the completed operation.
REQ-014 The module SHALL have ports flags  output  4  {N,Z,V,C} status register; busy  output  1  state != IDLE.

Function
REQ-015 The block SHALL implement states IDLE, EXEC, RESP; IDLE->EXEC on handshake, EXEC->RESP unconditionally, RESP->IDLE unconditionally.
REQ-016 In IDLE, reqi_ready SHALL be combinationally high only for the granted requester with reqi_valid high; both readys SHALL be low in EXEC and RESP.
REQ-017 Arbitration SHALL be round-robin: single valid -> that requester; both valid -> requester not in last_grant; last_grant updates on each handshake.
REQ-018 On handshake edge, the granted op, a, b, ci SHALL be latched into alu_op/alu_a/alu_b/alu_ci, and s and requester id latched internally.
REQ-019 alu_* outputs SHALL hold their last latched values outside handshake edges.
REQ-020 At the EXEC->RESP edge, alu_y SHALL be captured into rsp_y and {alu_n,alu_z,alu_v,alu_co} into rsp_nzvc.
REQ-021 At the same edge, flags SHALL load {alu_n,alu_z,alu_v,alu_co} iff latched s=1; otherwise flags SHALL hold.
REQ-022 In RESP, rsp_valid of the latched requester SHALL be high for exactly one cycle; the other rsp_valid SHALL stay low.
REQ-023 Latency SHALL be fixed: handshake at edge E0 -> rsp_valid high in the cycle after E0+2 edges... precisely, high during the cycle between E0+2 and E0+3 edges... shall be stated as: rsp_valid high in the second cycle after the handshake cycle; next handshake possible at earliest in the third cycle after it.
REQ-024 rsp_y and rsp_nzvc SHALL hold their values until the next EXEC->RESP edge.
REQ-025 A requester dropping valid before handshake SHALL be ignored without affecting last_grant.
REQ-026 Operands SHALL be passed unmodified; the block SHALL perform no arithmetic itself.

Reset
REQ-027 On rst_n low, immediately and regardless of clk: state=IDLE, last_grant=1 (req0 wins first tie), flags=0, rsp_y=0, rsp_nzvc=0, alu_op/alu_a/alu_b/alu_ci=0, rsp0_valid=rsp1_valid=0, busy=0.
REQ-028 Reset asserted in EXEC or RESP SHALL abort the transaction: no rsp_valid pulse, flags not updated.
REQ-029 After rst_n deasserts, the first handshake SHALL occur no earlier than the first rising edge with rst_n high.

Verification
REQ-030 Single req0: op=4, a=10, b=15, s=1 with ALU adding -> req0_ready 1 cycle, rsp0_valid 2 cycles later, rsp_y=25, flags=0000.
REQ-031 Overflow: req1 op=4, a=7FFFFFFF, b=1, s=1 -> rsp_y=80000000, rsp_nzvc=1010, flags=1010, rsp1_valid only.
REQ-032 Both valid continuously after reset -> grants alternate req0, req1, req0, req1, one handshake every 3 cycles, busy high except IDLE cycles.
REQ-033 s=0 operation with result 0 -> rsp_nzvc Z=1, flags unchanged from previous value.
REQ-034 rst_n pulsed low during EXEC of a req0 operation -> no rsp0_valid, flags=0, alu_*=0, next tie granted to req0.
REQ-035 req1 valid alone then withdrawn while in EXEC of req0 -> no req1 handshake, last_grant=0, next lone req1 granted normally.
